dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data-memory port: services loads and stores issued from the M stage.
//  Holds a word-addressed data RAM and inserts a fixed, parameterised access latency.
//  Latency is applied by asserting memstall back to the hazard unit, which freezes F/D/E/M and bubbles W.
//  Replaces the ideal single-cycle data memory so stall paths can be exercised.
// PARAMETERS
//  DEPTH    64  number of 32-bit words; power of two, >=2
//  LATENCY  2   BUSY cycles per access; legal range 1..15
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  memread    in   1   load request from M stage (memtoregM)
//  memwrite   in   1   store request from M stage
//  adr        in   32  byte address (aluoutM)
//  writedata  in   32  store data (writedataM)
//  readdata   out  32  load data (readdataM); valid in DONE
//  memstall   out  1   pipeline must hold while high
//  misalign   out  1   one-cycle pulse in DONE if adr[1:0]!=0
// BEHAVIOUR
//  - req = memread|memwrite. Index = adr[$clog2(DEPTH)+1:2]; upper address bits ignored (aliasing wrap).
//  - FSM states IDLE, BUSY, DONE; 4-bit down-counter cnt.
//    * IDLE: if req, cnt<=LATENCY-1 and go to BUSY; else stay.
//    * BUSY: if !req, abort to IDLE (flush): no write, readdata unchanged.
//      Else if cnt!=0, decrement.
//      Else (cnt==0) perform the access on the edge and go to DONE.
//    * DONE: unconditional return to IDLE next edge.
//  - memstall = (IDLE & req) | BUSY; combinational; low in DONE.
//  - Each access therefore stalls LATENCY+1 cycles.
//  - The access completes on the edge BUSY->DONE:
//    * store: RAM[index]<=writedata.
//    * load: readdata<=RAM[index].
//    * both asserted: write performed; readdata<=pre-write contents.
//  - readdata is registered and holds its value until the next completing load.
//  - Misaligned (adr[1:0]!=0): full latency, no RAM write, readdata<=0, misalign=1 in DONE only.
//  - Request inputs must be stable while memstall=1. A change in adr/data during BUSY is sampled at completion.
//  - Back-to-back: a new request seen in IDLE the cycle after DONE starts a fresh access; no zero-stall path exists.
//  - Reset (async, any state): FSM->IDLE, cnt=0, readdata=0, memstall=0, misalign=0.
//    RAM contents are not cleared; an in-flight store is dropped.
// STRUCTURE
//  - Shared package mem_pkg holds:
//    * typedef enum logic[1:0] {IDLE, BUSY, DONE} memstate_t
//    * localparam MAXLAT=15
//    * word-index function widx(adr, DEPTH)
//  - Sub-module mem_array #(DEPTH): single-port synchronous RAM with we, idx, wd, rd, registered read, no reset.
//    Instantiated once.
//  - FSM, counter and stall logic live in dmem_responder; readdata register is in mem_array, cleared via an output-zeroing flop.
// TESTING
//  1. LATENCY=2; store adr=0x10 data=0xDEADBEEF held until stall drops
//     -> memstall high exactly 3 cycles, then low 1 cycle (DONE).
//     Load adr=0x10 -> readdata=0xDEADBEEF in its DONE cycle.
//  2. Misaligned store adr=0x13 data=0x1 -> 3 stall cycles, misalign=1 in DONE, RAM[4] unchanged.
//     Load 0x13 -> readdata=0, misalign pulse.
//  3. DEPTH=64; store 0xA5A5A5A5 to adr=0x100 (aliases index 0) -> load adr=0x0 returns 0xA5A5A5A5.
//  4. Store 0x11 to adr=0x20, then issue a store at 0x20 with data 0x22 and drop the request after 1 BUSY cycle
//     -> FSM back in IDLE, memstall=0; load 0x20 returns 0x11.
//  5. Assert reset mid-BUSY during store of 0x55 to adr=0x8 (RAM[2] pre-set 0x77)
//     -> immediately memstall=0, readdata=0; after release, load 0x8 returns 0x77.
//  6. memread&memwrite to adr=0xC (old 0x3), data 0x9 -> readdata=0x3; following load returns 0x9.
//     LATENCY=1 sweep -> 2 stall cycles per access.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the latency ceiling and the word-index helper.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} memstate_t;

    localparam int MAXLAT = 15;
    localparam int CNTW   = $clog2(MAXLAT + 1);

    // Word index with upper address bits masked away, so addresses alias modulo depth.
    function automatic logic [31:0] widx(input logic [31:0] adr, input int depth);
        return (adr >> 2) & (32'(depth) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with a registered read port.
// The RAM itself is never reset; only the output register clears, and it can load zero.
module mem_array #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic          zero,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wd;
    end

    // Reads sample pre-write contents when a load and store land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd <= '0;
        else if (re)
            rd <= zero ? '0 : mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage.
// Holds the pipeline via memstall for LATENCY+1 cycles per access, then completes it.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        memstall,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] CNTLOAD = CNTW'(LATENCY - 1);

    memstate_t     state;
    logic [CNTW-1:0] cnt;
    logic          req;
    logic          misal;
    logic          complete;
    logic [AW-1:0] idx;

    assign req      = memread | memwrite;
    assign misal    = adr[1:0] != 2'b00;
    assign idx      = AW'(widx(adr, DEPTH));
    assign complete = (state == BUSY) && req && (cnt == '0);

    // Reset forces the stall low immediately, even if a request is still presented.
    assign memstall = !reset && (((state == IDLE) && req) || (state == BUSY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt   <= CNTLOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        misalign <= misal;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_array #(.DEPTH(DEPTH)) uArray (
        .clk   (clk),
        .reset (reset),
        .we    (complete && memwrite && !misal),
        .re    (complete && (memread || misal)),
        .zero  (misal),
        .idx   (idx),
        .wd    (writedata),
        .rd    (readdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
// Requests are steered to whichever instance is selected by useLat1.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdReq, wrReq, useLat1;
    logic [31:0] adr, writedata;

    logic        memreadA, memwriteA, memstallA, misalignA;
    logic        memreadB, memwriteB, memstallB, misalignB;
    logic [31:0] readdataA, readdataB;
    logic        stallObs, misObs;
    logic [31:0] readObs;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign memreadA  = rdReq & ~useLat1;
    assign memwriteA = wrReq & ~useLat1;
    assign memreadB  = rdReq & useLat1;
    assign memwriteB = wrReq & useLat1;
    assign stallObs  = useLat1 ? memstallB : memstallA;
    assign misObs    = useLat1 ? misalignB : misalignA;
    assign readObs   = useLat1 ? readdataB : readdataA;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .memread(memreadA), .memwrite(memwriteA),
        .adr(adr), .writedata(writedata), .readdata(readdataA),
        .memstall(memstallA), .misalign(misalignA)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) dutLat1 (
        .clk(clk), .reset(reset), .memread(memreadB), .memwrite(memwriteB),
        .adr(adr), .writedata(writedata), .readdata(readdataB),
        .memstall(memstallB), .misalign(misalignB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request, hold it while stalled, capture outputs in the DONE cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, output int stalls,
                                 output logic [31:0] rdata, output logic mis);
        logic done;
        stalls = 0;
        done   = 1'b0;
        @(posedge clk);
        #1;
        rdReq = rd; wrReq = wr; adr = a; writedata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallObs) stalls++;
            else begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("doneReached", {31'b0, done}, 32'd1);
        rdata = readObs;
        mis   = misObs;
        @(posedge clk);
        #1;
        rdReq = 1'b0; wrReq = 1'b0;
    endtask

    task automatic doStore(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input int expStalls, input logic expMis);
        int s; logic [31:0] r; logic m;
        applyStimulus(1'b0, 1'b1, a, d, s, r, m);
        checkOutput({tag, ".stalls"}, 32'(s), 32'(expStalls));
        checkOutput({tag, ".misalign"}, {31'b0, m}, {31'b0, expMis});
    endtask

    task automatic doLoad(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] expData,
                          input int expStalls, input logic expMis);
        int s; logic [31:0] r; logic m;
        applyStimulus(rd, wr, a, d, s, r, m);
        checkOutput({tag, ".stalls"}, 32'(s), 32'(expStalls));
        checkOutput({tag, ".data"}, r, expData);
        checkOutput({tag, ".misalign"}, {31'b0, m}, {31'b0, expMis});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; rdReq = 1'b0; wrReq = 1'b0; useLat1 = 1'b0;
        adr = '0; writedata = '0;
        #12;
        checkOutput("reset.memstall", {31'b0, memstallA}, 32'd0);
        checkOutput("reset.readdata", readdataA, 32'd0);
        checkOutput("reset.misalign", {31'b0, misalignA}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic store then load, readdata holding afterwards
        doStore("st10", 32'h10, 32'hDEADBEEF, 3, 1'b0);
        doLoad("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        @(negedge clk);
        checkOutput("ld10.hold", readdataA, 32'hDEADBEEF);

        // Misaligned accesses
        doStore("st13", 32'h13, 32'h1, 3, 1'b1);
        @(negedge clk);
        checkOutput("st13.pulseEnds", {31'b0, misalignA}, 32'd0);
        doLoad("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        doLoad("ld13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 3, 1'b1);

        // Address aliasing past DEPTH words
        doStore("st100", 32'h100, 32'hA5A5A5A5, 3, 1'b0);
        doLoad("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 3, 1'b0);

        // Store aborted after one BUSY cycle leaves RAM and readdata untouched
        doStore("st20", 32'h20, 32'h11, 3, 1'b0);
        @(posedge clk);
        #1;
        wrReq = 1'b1; adr = 32'h20; writedata = 32'h22;
        @(posedge clk);
        #1;
        wrReq = 1'b0;
        @(negedge clk);
        checkOutput("abort.busyStall", {31'b0, memstallA}, 32'd1);
        @(negedge clk);
        checkOutput("abort.idleStall", {31'b0, memstallA}, 32'd0);
        checkOutput("abort.readdata", readdataA, 32'hA5A5A5A5);
        doLoad("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11, 3, 1'b0);

        // Reset in the middle of a store
        doStore("st8pre", 32'h8, 32'h77, 3, 1'b0);
        @(posedge clk);
        #1;
        wrReq = 1'b1; adr = 32'h8; writedata = 32'h55;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midReset.memstall", {31'b0, memstallA}, 32'd0);
        checkOutput("midReset.readdata", readdataA, 32'd0);
        wrReq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        doLoad("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 3, 1'b0);

        // Simultaneous load and store returns the old word
        doStore("stC", 32'hC, 32'h3, 3, 1'b0);
        doLoad("rwC", 1'b1, 1'b1, 32'hC, 32'h9, 32'h3, 3, 1'b0);
        doLoad("ldC", 1'b1, 1'b0, 32'hC, 32'h0, 32'h9, 3, 1'b0);

        // LATENCY=1 instance
        useLat1 = 1'b1;
        doStore("l1st4", 32'h4, 32'h1234, 2, 1'b0);
        doLoad("l1ld4", 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234, 2, 1'b0);
        doLoad("l1ld6", 1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
